// File: rtl/vedm_industries_converter_top_if.sv
// Tile pin bundle for the converter controller: enable, ADC sample,
// the unused bidirectional bank and the output byte.
// The master side belongs to whatever drives the tile pins; the slave
// side is the controller itself.
interface vedm_industries_converter_top_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/vedm_industries_converter_top.sv
// Renewable-energy converter controller.
// Averages a 4-sample window of the source-voltage ADC code, raises
// registered under/over-voltage flags, and trims the duty of a 256-step PWM
// once per period with a saturating integral step toward SETPOINT.
// uo_out = {telemetry[3:0], run, ov, uv, pwm}; the uio bank is unused.
// Optional feature macro: ENERGY_ACC_EN adds a 16-bit saturating energy
// accumulator (sum of avg over pwm-high clocks) and routes its top nibble
// to the telemetry field instead of avg[7:4].
module vedm_industries_converter_top #(
  parameter logic [7:0] SETPOINT  = 8'd100,
  parameter logic [7:0] UV_THRESH = 8'd60,
  parameter logic [7:0] OV_THRESH = 8'd200,
  parameter logic [7:0] DUTY_INIT = 8'd128,
  parameter logic [7:0] DUTY_MAX  = 8'd240,
  parameter logic [7:0] STEP      = 8'd4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  vedm_industries_converter_top_if.slave     bus
);

  // The live sample is the newest window tap, so only three history taps
  // are stored; avg then lags the input by exactly one clock.
  logic [7:0] tap0_q, tap1_q, tap2_q;
  logic [9:0] win_sum;
  logic [7:0] avg_d, avg_q;
  logic [1:0] avg_frac_unused;

  logic       uv_d, uv_q;
  logic       ov_d, ov_q;
  logic       run_d, run_q;
  logic       pwm_d, pwm_q;
  logic [7:0] cnt_d, cnt_q;
  logic [7:0] duty_d, duty_q;
  logic [8:0] duty_up;
  logic [3:0] telem;
  logic       unused_uio;

`ifdef ENERGY_ACC_EN
  logic [15:0] acc_d, acc_q;
  logic [16:0] acc_sum;
`endif

  // Window sum is 10 bits wide; dropping the two LSBs truncates the mean.
  always_comb begin
    win_sum = {2'b00, bus.ui_in} + {2'b00, tap0_q}
            + {2'b00, tap1_q}    + {2'b00, tap2_q};
    {avg_d, avg_frac_unused} = win_sum;
  end

  // Fault flags and PWM compare all look at the current registered state.
  always_comb begin
    uv_d  = (avg_q < UV_THRESH);
    ov_d  = (avg_q > OV_THRESH);
    run_d = bus.ena & rst_n;
    pwm_d = run_q & ~uv_q & ~ov_q & (cnt_q < duty_q);
    cnt_d = cnt_q + 8'd1;
  end

  // Integral duty step on the last count of the period; the new value is
  // first compared against cnt == 0 of the following period. Faults do not
  // suspend the loop, they only gate the PWM output.
  always_comb begin
    duty_up = {1'b0, duty_q} + {1'b0, STEP};
    duty_d  = duty_q;
    if (cnt_q == 8'hFF) begin
      if (avg_q > SETPOINT) begin
        duty_d = (duty_q > STEP) ? (duty_q - STEP) : 8'd0;
      end else if (avg_q < SETPOINT) begin
        duty_d = (duty_up > {1'b0, DUTY_MAX}) ? DUTY_MAX : duty_up[7:0];
      end
    end
  end

`ifdef ENERGY_ACC_EN
  // Energy estimate: add the averaged source level on every pwm-high clock,
  // pinning at full scale instead of wrapping.
  always_comb begin
    acc_sum = {1'b0, acc_q} + {9'd0, avg_q};
    acc_d   = acc_q;
    if (pwm_q) begin
      acc_d = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
    end
  end
`endif

  // All state: synchronous active-low reset, otherwise frozen while ena is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tap0_q <= 8'd0;
      tap1_q <= 8'd0;
      tap2_q <= 8'd0;
      avg_q  <= 8'd0;
      uv_q   <= 1'b0;
      ov_q   <= 1'b0;
      run_q  <= 1'b0;
      pwm_q  <= 1'b0;
      cnt_q  <= 8'd0;
      duty_q <= DUTY_INIT;
`ifdef ENERGY_ACC_EN
      acc_q  <= 16'd0;
`endif
    end else if (bus.ena) begin
      tap0_q <= bus.ui_in;
      tap1_q <= tap0_q;
      tap2_q <= tap1_q;
      avg_q  <= avg_d;
      uv_q   <= uv_d;
      ov_q   <= ov_d;
      run_q  <= run_d;
      pwm_q  <= pwm_d;
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
`ifdef ENERGY_ACC_EN
      acc_q  <= acc_d;
`endif
    end
  end

`ifdef ENERGY_ACC_EN
  assign telem = acc_q[15:12];
`else
  assign telem = avg_q[7:4];
`endif

  // pwm and run drop immediately with ena; flags and telemetry keep their
  // last registered values.
  assign bus.uo_out  = {telem, run_q & bus.ena, ov_q, uv_q, pwm_q & bus.ena};
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

  assign unused_uio = ^bus.uio_in;

endmodule

// File: tb/tb_vedm_industries_converter_top.sv
// Self-checking bench for vedm_industries_converter_top.
// A sample-window / period-level reference model predicts uo_out every clock;
// directed phases also measure pwm-high clocks per period against known duties.
module tb_vedm_industries_converter_top;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vedm_industries_converter_top_if bus_if ();

  vedm_industries_converter_top dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_win[$];
  int m_avg, m_cnt, m_duty, m_acc;
  bit m_uv, m_ov, m_pwm, m_run;

  int pcount;
  int periods[$];

  task automatic check_val(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input int x);
    int s;
    bit npwm;
    if (!r) begin
      m_win = {0, 0, 0, 0};
      m_avg = 0; m_cnt = 0; m_duty = 128; m_acc = 0;
      m_uv = 0; m_ov = 0; m_pwm = 0; m_run = 0;
    end else if (e) begin
      npwm = m_run && !m_uv && !m_ov && (m_cnt < m_duty);
      if (m_pwm) m_acc = (m_acc + m_avg > 65535) ? 65535 : m_acc + m_avg;
      if (m_cnt == 255) begin
        if (m_avg > 100)      m_duty = (m_duty - 4 < 0) ? 0 : m_duty - 4;
        else if (m_avg < 100) m_duty = (m_duty + 4 > 240) ? 240 : m_duty + 4;
      end
      m_uv = (m_avg < 60);
      m_ov = (m_avg > 200);
      m_win.push_front(x);
      void'(m_win.pop_back());
      s = 0;
      foreach (m_win[k]) s += m_win[k];
      m_avg = s / 4;
      m_cnt = (m_cnt + 1) % 256;
      m_run = 1;
      m_pwm = npwm;
    end
  endtask

  // One clock: predict, advance, sample at the falling edge, compare.
  task automatic step(input string tag);
    bit live;
    int src;
    int tele;
    logic [7:0] expv;
    live = rst_n && bus_if.ena;
    src  = m_cnt;
    model_edge(rst_n, bus_if.ena, int'(bus_if.ui_in));
    @(posedge clk);
    @(negedge clk);
`ifdef ENERGY_ACC_EN
    tele = m_acc / 4096;
`else
    tele = m_avg / 16;
`endif
    expv = {tele[3:0], bus_if.ena & m_run, m_ov, m_uv, bus_if.ena & m_pwm};
    check_val({tag, "_uo_out"}, int'(bus_if.uo_out), int'(expv));
    if (live) begin
      pcount += int'(bus_if.uo_out[0]);
      if (src == 255) begin
        periods.push_back(pcount);
        pcount = 0;
      end
    end
  endtask

  task automatic run_periods(input int n, input string tag);
    periods.delete();
    pcount = 0;
    repeat (n * 256) step(tag);
  endtask

  initial begin
    int hold;
    bus_if.ena    = 1'b0;
    bus_if.ui_in  = 8'd0;
    bus_if.uio_in = 8'hA5;
    rst_n = 1'b0;
    @(negedge clk);

    repeat (5) step("reset");
    check_val("reset_uio_oe", int'(bus_if.uio_oe), 0);
    check_val("reset_uio_out", int'(bus_if.uio_out), 0);

    rst_n = 1'b1;
    bus_if.ui_in = 8'd150;
    repeat (20) step("disabled");

    // cnt starts at 0 here, so each phase below is period-aligned.
    bus_if.ena = 1'b1;
    run_periods(10, "avg150");
    check_val("p0_startup_count", periods[0], 125);
    check_val("p1_duty124", periods[1], 124);
    check_val("p7_duty100", periods[7], 100);
    check_val("p9_duty92", periods[9], 92);

    bus_if.ui_in = 8'd45;
    run_periods(42, "uv45");
    check_val("uv_pwm_off_p1", periods[1], 0);
    check_val("uv_pwm_off_p41", periods[41], 0);

    // duty is now capped at 240; two over-voltage updates take it to 232
    bus_if.ui_in = 8'd230;
    run_periods(2, "ov230");
    check_val("ov_pwm_off_p1", periods[1], 0);

    bus_if.ui_in = 8'd100;
    run_periods(3, "resume100");
    check_val("resume_p1_duty232", periods[1], 232);
    check_val("hold_p2_duty232", periods[2], 232);

    // reset mid-period restarts the counter
    repeat (77) step("pre_midreset");
    rst_n = 1'b0;
    step("midreset");
    rst_n = 1'b1;
    bus_if.ui_in = 8'd120;
    run_periods(2, "after_midreset");
    check_val("midreset_p1_duty124", periods[1], 124);

    hold = 0;
    for (int i = 0; i < 15000; i++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 600);
        case ($urandom_range(0, 3))
          0: bus_if.ui_in = 8'($urandom_range(0, 255));
          1: bus_if.ui_in = 8'($urandom_range(55, 65));
          2: bus_if.ui_in = 8'($urandom_range(95, 105));
          default: bus_if.ui_in = 8'($urandom_range(195, 205));
        endcase
      end
      hold--;
      bus_if.ena    = ($urandom_range(0, 15) != 0);
      bus_if.uio_in = 8'($urandom_range(0, 255));
      rst_n         = ($urandom_range(0, 999) != 0);
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
